// File: rtl/dist_hdr_fifo_param.sv
// dist_hdr_fifo_param
//   Single-clock header FIFO on distributed (LUT) RAM. It buffers per-channel
//   waveform header words between the trigger/header builder and the readout
//   arbiter. All DEPTH = 2**ADDR_W entries are usable. Reads have one cycle of
//   latency into a registered dout, qualified by dout_valid.
//
// Ports
//   clk          clock, rising edge
//   srst         synchronous active-high reset (pointers, flags, count, dout)
//   din          write data, DATA_W bits
//   wr_en        write request
//   rd_en        read request
//   dout         registered read data, holds between reads
//   dout_valid   1-cycle pulse when dout carries a newly read word
//   full         data_count == DEPTH
//   almost_full  data_count >= AFULL_THR
//   empty        data_count == 0
//   data_count   occupancy 0..DEPTH (ADDR_W+1 bits)
//   overflow     1-cycle pulse: a write was rejected
//   underflow    1-cycle pulse: a read was rejected
module dist_hdr_fifo_param #(
  parameter int DATA_W    = 108,
  parameter int ADDR_W    = 5,
  parameter int AFULL_THR = 28
) (
  input  logic              clk,
  input  logic              srst,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              full,
  output logic              almost_full,
  output logic              empty,
  output logic [ADDR_W:0]   data_count,
  output logic              overflow,
  output logic              underflow
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(AFULL_THR);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rd_acc;
  logic              wr_acc;
  logic [ADDR_W:0]   count_nxt;

  // A write into a full FIFO is allowed when a read frees a slot in the same cycle.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_comb begin
    count_nxt = data_count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = data_count + 1'b1;
      2'b01:   count_nxt = data_count - 1'b1;
      default: count_nxt = data_count;
    endcase
  end

  // RAM array: no reset so it maps onto LUT RAM; reset still blocks writes.
  always_ff @(posedge clk) begin
    if (wr_acc && !srst) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, count, flags and registered read port.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      data_count  <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      dout_valid  <= rd_acc;
      data_count  <= count_nxt;
      // Flags come from the next count so they line up with data_count.
      empty       <= (count_nxt == '0);
      full        <= (count_nxt == DEPTH_CNT);
      almost_full <= (count_nxt >= AFULL_CNT);
      overflow    <= wr_en & ~wr_acc;
      underflow   <= rd_en & empty;
    end
  end

endmodule

// File: tb/tb_dist_hdr_fifo_param.sv
module tb_dist_hdr_fifo_param;

  localparam int DW    = 108;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int AFT   = 28;

  logic          clk = 1'b0;
  logic          srst = 1'b1;
  logic [DW-1:0] din = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          full;
  logic          almost_full;
  logic          empty;
  logic [AW:0]   data_count;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] mq[$];     // words stored in the FIFO
  logic [DW-1:0] sb[$];     // words read, awaiting dout_valid
  logic [DW-1:0] m_dout;
  logic          m_dv, m_ovf, m_unf;

  dist_hdr_fifo_param #(.DATA_W(DW), .ADDR_W(AW), .AFULL_THR(AFT)) dut (
    .clk(clk), .srst(srst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout), .dout_valid(dout_valid), .full(full),
    .almost_full(almost_full), .empty(empty), .data_count(data_count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model after an edge.
  task automatic check_model();
    logic [DW-1:0] w;
    chk("dout_valid", dout_valid, m_dv);
    if (dout_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 1, 0);
      end else begin
        w = sb.pop_front();
        chk("sb_dout", dout, w);
      end
    end
    chk("dout", dout, m_dout);
    chk("data_count", data_count, mq.size());
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == DEPTH);
    chk("almost_full", almost_full, mq.size() >= AFT);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
  endtask

  // One clock with the given requests; the model follows the same edge.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    logic m_empty, m_full, ra, wa;
    m_empty = (mq.size() == 0);
    m_full  = (mq.size() == DEPTH);
    ra = r & ~m_empty;
    wa = w & (~m_full | ra);
    wr_en = w; rd_en = r; din = d;
    @(posedge clk); #1;
    m_dv  = ra;
    m_ovf = w & ~wa;
    m_unf = r & m_empty;
    if (ra) begin
      m_dout = mq.pop_front();
      sb.push_back(m_dout);
    end
    if (wa) mq.push_back(d);
    check_model();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_reset(input int n, input logic w, input logic r);
    srst = 1'b1; wr_en = w; rd_en = r; din = 'h55;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_underflow", underflow, 1'b0);
      chk("rst_dout_valid", dout_valid, 1'b0);
    end
    srst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    mq.delete(); sb.delete();
    m_dout = '0; m_dv = 0; m_ovf = 0; m_unf = 0;
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_afull", almost_full, 1'b0);
    chk("rst_count", data_count, 0);
    chk("rst_dout", dout, 0);
  endtask

  typedef struct {
    logic          wr, rd;
    logic [DW-1:0] din;
    int            cnt;
    logic          emp, dv, unf;
    logic [DW-1:0] dout;
  } vec_t;

  function automatic vec_t mk(logic wr, logic rd, logic [DW-1:0] d, int cnt,
                              logic emp, logic dv, logic unf, logic [DW-1:0] q);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = d; v.cnt = cnt;
    v.emp = emp; v.dv = dv; v.unf = unf; v.dout = q;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [DW-1:0] pat;
    // Test 2 and test 5 as fixed vectors
    for (int i = 1; i <= 5; i++) tbl.push_back(mk(1, 0, DW'(i), i, 0, 0, 0, 0));
    for (int i = 1; i <= 5; i++) tbl.push_back(mk(0, 1, 0, 5 - i, i == 5, 1, 0, DW'(i)));
    tbl.push_back(mk(1, 1, 'hABC, 1, 0, 0, 1, 'h5));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 'hABC));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 1, 'hABC));

    // Test 1: reset with both requests held
    m_dout = '0; m_dv = 0; m_ovf = 0; m_unf = 0;
    @(posedge clk); #1;
    do_reset(3, 1'b1, 1'b1);

    foreach (tbl[i]) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].din);
      chk($sformatf("vec%0d_count", i), data_count, tbl[i].cnt);
      chk($sformatf("vec%0d_empty", i), empty, tbl[i].emp);
      chk($sformatf("vec%0d_dv", i), dout_valid, tbl[i].dv);
      chk($sformatf("vec%0d_unf", i), underflow, tbl[i].unf);
      chk($sformatf("vec%0d_dout", i), dout, tbl[i].dout);
    end

    // Test 3: fill, almost_full at 28, full at 32, overflow on 33rd
    for (int i = 1; i <= DEPTH; i++) begin
      step(1, 0, DW'(i));
      chk("fill_afull", almost_full, i >= AFT);
      chk("fill_full", full, i == DEPTH);
    end
    step(1, 0, 'hDEAD);
    chk("ovf_pulse", overflow, 1'b1);
    chk("ovf_count", data_count, DEPTH);
    step(0, 0, 0);
    chk("ovf_cleared", overflow, 1'b0);
    step(0, 1, 0);
    chk("first_after_ovf", dout, 1);
    chk("first_after_ovf_dv", dout_valid, 1'b1);
    step(1, 0, 'h21);
    chk("refull", full, 1'b1);

    // Test 4: full, simultaneous read/write across pointer wrap
    pat = 'h1000;
    for (int i = 0; i < 40; i++) begin
      step(1, 1, pat);
      chk("rw_full", full, 1'b1);
      chk("rw_count", data_count, DEPTH);
      chk("rw_ovf", overflow, 1'b0);
      pat = pat + 1;
    end
    // Drain a few so the tail of the pattern is also read back
    for (int i = 0; i < 15; i++) step(0, 1, 0);
    chk("mid_count", data_count, 17);

    // Test 6: reset in the middle of a read burst
    do_reset(1, 1'b0, 1'b1);
    step(0, 0, 0);
    chk("post_rst_dv", dout_valid, 1'b0);
    step(1, 0, 'h7);
    step(0, 1, 0);
    chk("post_rst_dout", dout, 'h7);
    chk("post_rst_dv2", dout_valid, 1'b1);
    step(0, 0, 0);
    chk("post_rst_empty", empty, 1'b1);

    // Random mix against the model
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom));
    end
    for (int i = 0; i < DEPTH + 2; i++) step(0, 1, 0);
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
